// File: rtl/pinball_tone_gen.sv
// pinball_tone_gen: square-wave note generator with a silent gap on retrigger
// and a falling-pitch sweep for the game-over code.
`timescale 1ns/1ps
module pinball_tone_gen #(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned GAP_FRAMES  = 1,
  parameter int unsigned SWEEP_CODE  = 10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        soundEnable,
  input  logic [3:0]  frequency,
  output logic        tone_out,
  output logic        playing,
  output logic [3:0]  cur_code,
  output logic [15:0] half_period
);

  localparam int unsigned CODE_W = 4;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned GAP_W  = 3;
  localparam int unsigned SUM_W  = DIV_W + 1;

  localparam logic [CODE_W-1:0] SWEEP_C  = CODE_W'(SWEEP_CODE);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_FRAMES);

  // Half-period divisor for a note frequency; 0 Hz marks a silent code.
  function automatic logic [DIV_W-1:0] div_of(input int unsigned hz);
    if (hz == 0) return '0;
    return DIV_W'(CLK_FREQ_HZ / (2 * hz));
  endfunction

  localparam logic [DIV_W-1:0] DIV_TBL [16] = '{
    div_of(0),    div_of(440),  div_of(523),  div_of(659),
    div_of(698),  div_of(784),  div_of(880),  div_of(392),
    div_of(988),  div_of(1047), div_of(262),  div_of(0),
    div_of(0),    div_of(0),    div_of(0),    div_of(0)
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_tone;
  logic               r_playing;
  logic [CODE_W-1:0]  r_code;
  logic [DIV_W-1:0]   r_half;
  logic [DIV_W-1:0]   r_cnt;
  logic [GAP_W-1:0]   r_gap;

  state_t             w_state_nxt;
  logic               w_tone_nxt;
  logic               w_playing_nxt;
  logic [CODE_W-1:0]  w_code_nxt;
  logic [DIV_W-1:0]   w_half_nxt;
  logic [DIV_W-1:0]   w_cnt_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;

  logic [DIV_W-1:0]   w_new_div;
  logic [DIV_W-1:0]   w_cur_div;
  logic               w_new_silent;
  logic               w_code_chg;
  logic [SUM_W-1:0]   w_sweep_sum;
  logic [DIV_W-1:0]   w_sweep_sat;

  // Table lookups and the saturating 1/8 pitch-drop step.
  always_comb begin
    w_new_div    = DIV_TBL[frequency];
    w_cur_div    = DIV_TBL[r_code];
    w_new_silent = (w_new_div == '0);
    w_code_chg   = (frequency != r_code);
    w_sweep_sum  = {1'b0, r_half} + SUM_W'(r_half >> 3);
    w_sweep_sat  = w_sweep_sum[SUM_W-1] ? '1 : w_sweep_sum[DIV_W-1:0];
  end

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state   <= S_IDLE;
      r_tone    <= 1'b0;
      r_playing <= 1'b0;
      r_code    <= '0;
      r_half    <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tone    <= w_tone_nxt;
      r_playing <= w_playing_nxt;
      r_code    <= w_code_nxt;
      r_half    <= w_half_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gap     <= w_gap_nxt;
    end
  end

  // Next-state and next-register logic; a code change outranks frame pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_tone_nxt  = r_tone;
    w_code_nxt  = r_code;
    w_half_nxt  = r_half;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;

    unique case (r_state)
      S_IDLE: begin
        w_tone_nxt = 1'b0;
        w_cnt_nxt  = '0;
        if (soundEnable && !w_new_silent) begin
          w_state_nxt = S_PLAY;
          w_code_nxt  = frequency;
          w_half_nxt  = w_new_div;
          w_cnt_nxt   = w_new_div - DIV_W'(1);
          w_tone_nxt  = 1'b1;
        end
      end

      S_PLAY: begin
        if (!soundEnable) begin
          w_state_nxt = S_IDLE;
          w_tone_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else if (w_code_chg) begin
          w_tone_nxt = 1'b0;
          w_cnt_nxt  = '0;
          if (w_new_silent) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_GAP;
            w_code_nxt  = frequency;
            w_gap_nxt   = GAP_LOAD;
          end
        end else begin
          if (r_cnt == '0) begin
            w_tone_nxt = ~r_tone;
            w_cnt_nxt  = r_half - DIV_W'(1);
          end else begin
            w_cnt_nxt  = r_cnt - DIV_W'(1);
          end
          if (startOfFrame && (r_code == SWEEP_C)) begin
            w_half_nxt = w_sweep_sat;
          end
        end
      end

      S_GAP: begin
        w_tone_nxt = 1'b0;
        w_cnt_nxt  = '0;
        if (!soundEnable) begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = '0;
        end else if (w_code_chg) begin
          if (w_new_silent) begin
            w_state_nxt = S_IDLE;
            w_gap_nxt   = '0;
          end else begin
            w_code_nxt = frequency;
            w_gap_nxt  = GAP_LOAD;
          end
        end else if (startOfFrame) begin
          if (r_gap <= GAP_W'(1)) begin
            w_state_nxt = S_PLAY;
            w_gap_nxt   = '0;
            w_half_nxt  = w_cur_div;
            w_cnt_nxt   = w_cur_div - DIV_W'(1);
            w_tone_nxt  = 1'b1;
          end else begin
            w_gap_nxt = r_gap - GAP_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_tone_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_gap_nxt   = '0;
      end
    endcase

    w_playing_nxt = (w_state_nxt == S_PLAY);
  end

  assign tone_out    = r_tone;
  assign playing     = r_playing;
  assign cur_code    = r_code;
  assign half_period = r_half;

endmodule
